// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: scancode constants, key bit indices, FSM state and event types shared by the key controller
package ps2_key_pkg;

    localparam logic [7:0] CODE_E0     = 8'hE0;
    localparam logic [7:0] CODE_F0     = 8'hF0;
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_BAT    = 8'hAA;
    localparam logic [7:0] CODE_ECHO   = 8'hEE;
    localparam logic [7:0] CODE_RESEND = 8'hFE;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_FIRE  = 4;
    localparam int KEY_START = 5;

    // bit 0 tracks a pending E0, bit 1 a pending F0
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EXT     = 2'b01,
        ST_BRK     = 2'b10,
        ST_EXT_BRK = 2'b11
    } state_t;

    typedef struct packed {
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    localparam int EV_W = $bits(ev_t);

    function automatic logic is_reply(input logic [7:0] c);
        return c == CODE_ACK || c == CODE_BAT || c == CODE_ECHO || c == CODE_RESEND;
    endfunction

    // letter keys, space and enter only count without the E0 prefix; arrow/keypad codes count either way
    function automatic logic [7:0] key_mask(input logic ext, input logic [7:0] c);
        logic [7:0] m;
        m = '0;
        m[KEY_UP]    = c == SC_UP    || (!ext && c == SC_W);
        m[KEY_DOWN]  = c == SC_DOWN  || (!ext && c == SC_S);
        m[KEY_LEFT]  = c == SC_LEFT  || (!ext && c == SC_A);
        m[KEY_RIGHT] = c == SC_RIGHT || (!ext && c == SC_D);
        m[KEY_FIRE]  = !ext && c == SC_SPACE;
        m[KEY_START] = !ext && c == SC_ENTER;
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// ps2_key_ctrl_if: scancode input, key bitmap and event handshake between receiver, controller and game logic
interface ps2_key_ctrl_if;

    logic       valid;
    logic [7:0] code;
    logic [7:0] keys;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_rel;
    logic       ovf;

    modport master (
        output valid, code, ev_ready,
        input  keys, ev_valid, ev_code, ev_ext, ev_rel, ovf
    );

    modport slave (
        input  valid, code, ev_ready,
        output keys, ev_valid, ev_code, ev_ext, ev_rel, ovf
    );

endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO with a combinational head that holds the last popped value while empty
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_pop  = pop_i & ~empty_o;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = push_i & (~full_o | do_pop);
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign head_o  = empty_o ? last_q : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) begin
                rd_q   <= rd_q + AW'(1);
                last_q <= mem_q[rd_q];
            end
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: tracks PS/2 E0/F0 prefixes, keeps the arcade key bitmap and queues key events
module ps2_key_ctrl
    import ps2_key_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_key_ctrl_if.slave bus
);

    localparam int            TW       = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;
    logic [7:0]    keys_q;
    logic [7:0]    keys_d;
    logic [7:0]    mask;
    logic          ovf_q;
    logic          ovf_d;
    logic          emit;
    logic          full;
    logic          empty;
    logic          pop;
    ev_t           ev_d;
    ev_t           head;

    assign pop = ~empty & bus.ev_ready;

    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        ev_d    = '{rel: state_q inside {ST_BRK, ST_EXT_BRK},
                    ext: state_q inside {ST_EXT, ST_EXT_BRK},
                    code: bus.code};
        tmo_d   = (bus.valid || state_q == ST_IDLE) ? '0 : tmo_q + TW'(1);
        if (bus.valid) begin
            if (bus.code == CODE_E0) state_d = ev_d.rel ? ST_EXT_BRK : ST_EXT;
            else if (bus.code == CODE_F0) state_d = ev_d.ext ? ST_EXT_BRK : ST_BRK;
            else begin
                state_d = ST_IDLE;
                emit    = !(state_q == ST_IDLE && is_reply(bus.code));
            end
        end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
        end
        mask   = key_mask(ev_d.ext, ev_d.code);
        keys_d = !emit ? keys_q : ev_d.rel ? keys_q & ~mask : keys_q | mask;
        // keys still follow a dropped event; only the queue loses it
        ovf_d  = ovf_q | (emit & full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            keys_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            keys_q  <= keys_d;
            ovf_q   <= ovf_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (emit),
        .pop_i   (pop),
        .din_i   (ev_d),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign bus.keys     = keys_q;
    assign bus.ev_valid = ~empty;
    assign bus.ev_code  = head.code;
    assign bus.ev_ext   = head.ext;
    assign bus.ev_rel   = head.rel;
    assign bus.ovf      = ovf_q;

endmodule
